// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : 640x480@60 timing constants, counter/colour widths and
//               a half-open window helper for the sync decoders.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_cnt_w     = 10;
    localparam int c_rgb_w     = 12;

    localparam int c_h_visible = 640;
    localparam int c_h_front   = 16;
    localparam int c_h_sync    = 96;
    localparam int c_h_back    = 48;
    localparam int c_v_visible = 480;
    localparam int c_v_front   = 10;
    localparam int c_v_sync    = 2;
    localparam int c_v_back    = 33;
    localparam int c_pix_div   = 4;

    typedef logic [c_cnt_w-1:0] cnt_t;
    typedef logic [c_rgb_w-1:0] rgb_t;

    function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pix_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : pix_tick_gen
// Description : Divides clk by PIX_DIV; pix_tick is high while the divider
//               sits on its last count.
// Revision    : 1.0 - initial release
// ============================================================================
module pix_tick_gen #(
    parameter int PIX_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    localparam int                 c_div_w    = $clog2(PIX_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(PIX_DIV - 1);

    logic [c_div_w-1:0] r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_div == c_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_div_w'(1);
        end
    end

    assign pix_tick = (r_div == c_div_last);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster counters, sync generation and colour output with a
//               tick-advanced delay line matching the scene memory latency.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = c_h_visible,
    parameter int H_FRONT   = c_h_front,
    parameter int H_SYNC    = c_h_sync,
    parameter int H_BACK    = c_h_back,
    parameter int V_VISIBLE = c_v_visible,
    parameter int V_FRONT   = c_v_front,
    parameter int V_SYNC    = c_v_sync,
    parameter int V_BACK    = c_v_back,
    parameter int PIX_DIV   = c_pix_div,
    parameter int PIPE_DLY  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [c_rgb_w-1:0] pixel_in,
    output logic [c_cnt_w-1:0] h_cnt,
    output logic [c_cnt_w-1:0] v_cnt,
    output logic               pix_tick,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b
);

    localparam cnt_t c_h_last     = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam cnt_t c_v_last     = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam cnt_t c_h_vis      = cnt_t'(H_VISIBLE);
    localparam cnt_t c_v_vis      = cnt_t'(V_VISIBLE);
    localparam cnt_t c_hs_start   = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t c_hs_end     = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam cnt_t c_vs_start   = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t c_vs_end     = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

    logic w_pix_tick;
    cnt_t r_h_cnt;
    cnt_t r_v_cnt;
    logic w_vis;
    logic w_hs_n;
    logic w_vs_n;
    logic w_vis_d;
    logic w_hs_d;
    logic w_vs_d;
    logic r_hsync;
    logic r_vsync;
    rgb_t r_rgb;

    pix_tick_gen #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (w_pix_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_pix_tick) begin
            if (r_h_cnt == c_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + cnt_t'(1);
            end else begin
                r_h_cnt <= r_h_cnt + cnt_t'(1);
            end
        end
    end

    assign w_vis  = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
    assign w_hs_n = !in_window(r_h_cnt, c_hs_start, c_hs_end);
    assign w_vs_n = !in_window(r_v_cnt, c_vs_start, c_vs_end);

    // Delay stages reset to "blank, syncs idle" so nothing glitches after reset.
    if (PIPE_DLY == 0) begin : g_no_dly
        assign w_vis_d = w_vis;
        assign w_hs_d  = w_hs_n;
        assign w_vs_d  = w_vs_n;
    end else begin : g_dly
        logic [PIPE_DLY-1:0] r_vis_dly;
        logic [PIPE_DLY-1:0] r_hs_dly;
        logic [PIPE_DLY-1:0] r_vs_dly;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vis_dly <= '0;
                r_hs_dly  <= '1;
                r_vs_dly  <= '1;
            end else if (w_pix_tick) begin
                r_vis_dly <= (r_vis_dly << 1) | PIPE_DLY'(w_vis);
                r_hs_dly  <= (r_hs_dly  << 1) | PIPE_DLY'(w_hs_n);
                r_vs_dly  <= (r_vs_dly  << 1) | PIPE_DLY'(w_vs_n);
            end
        end

        assign w_vis_d = r_vis_dly[PIPE_DLY-1];
        assign w_hs_d  = r_hs_dly[PIPE_DLY-1];
        assign w_vs_d  = r_vs_dly[PIPE_DLY-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= '0;
        end else if (w_pix_tick) begin
            r_hsync <= w_hs_d;
            r_vsync <= w_vs_d;
            r_rgb   <= w_vis_d ? pixel_in : '0;
        end
    end

    assign h_cnt       = r_h_cnt;
    assign v_cnt       = r_v_cnt;
    assign pix_tick    = w_pix_tick;
    assign frame_start = w_pix_tick && (r_h_cnt == '0) && (r_v_cnt == '0);
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for a default-timing instance and a small
//               PIPE_DLY=2 instance, against a tick-index arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct {
        int h;
        int v;
        bit fs;
        bit hs;
        bit vs;
        int r;
        int g;
        int b;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   const_mode = 1'b0;
    int   seed = 0;

    always #5 clk = ~clk;

    task automatic check(input int dut, input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0d, expected %0d (t=%0t)", dut, name, act, exp, $time);
        end
    endtask

    // Scene ROM contents: either a seeded hash of the address or a flat colour.
    function automatic int scene(input int h, input int v);
        if (const_mode)
            return 32'hABC;
        return ((h * 73 + v * 151 + seed) ^ (h * v + (seed >> 7))) & 32'hFFF;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int HV  = (gi == 0) ? 640 : 24;
        localparam int HF  = (gi == 0) ? 16  : 4;
        localparam int HS  = (gi == 0) ? 96  : 6;
        localparam int HB  = (gi == 0) ? 48  : 6;
        localparam int VV  = (gi == 0) ? 480 : 10;
        localparam int VF  = (gi == 0) ? 10  : 2;
        localparam int VS  = (gi == 0) ? 2   : 2;
        localparam int VB  = (gi == 0) ? 33  : 3;
        localparam int DIV = (gi == 0) ? 4   : 3;
        localparam int DLY = (gi == 0) ? 1   : 2;
        localparam int HT  = HV + HF + HS + HB;
        localparam int VT  = VV + VF + VS + VB;

        logic [11:0] pixel_in;
        logic [9:0]  h_cnt;
        logic [9:0]  v_cnt;
        logic        pix_tick;
        logic        frame_start;
        logic        hsync;
        logic        vsync;
        logic [3:0]  vga_r;
        logic [3:0]  vga_g;
        logic [3:0]  vga_b;

        exp_t exp_q[$];
        int   hist_h[$];
        int   hist_v[$];

        vga_timing_gen #(
            .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
            .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
            .PIX_DIV   (DIV), .PIPE_DLY (DLY)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .pixel_in    (pixel_in),
            .h_cnt       (h_cnt),
            .v_cnt       (v_cnt),
            .pix_tick    (pix_tick),
            .frame_start (frame_start),
            .hsync       (hsync),
            .vsync       (vsync),
            .vga_r       (vga_r),
            .vga_g       (vga_g),
            .vga_b       (vga_b)
        );

        // Expected state during the k-th pixel tick after reset release: raster
        // position k, with sync/colour reflecting position k-1-DLY.
        function automatic exp_t expect_at(input int k);
            exp_t e;
            int   j;
            int   jh;
            int   jv;
            int   p;
            e.h  = k % HT;
            e.v  = (k / HT) % VT;
            e.fs = (e.h == 0) && (e.v == 0);
            j    = k - 1 - DLY;
            e.hs = 1'b1; e.vs = 1'b1; e.r = 0; e.g = 0; e.b = 0;
            if (j >= 0) begin
                jh   = j % HT;
                jv   = (j / HT) % VT;
                e.hs = !((jh >= HV + HF) && (jh < HV + HF + HS));
                e.vs = !((jv >= VV + VF) && (jv < VV + VF + VS));
                if ((jh < HV) && (jv < VV)) begin
                    p   = scene(jh, jv);
                    e.r = (p >> 8) & 15;
                    e.g = (p >> 4) & 15;
                    e.b = p & 15;
                end
            end
            return e;
        endfunction

        // Reference model: counts active edges since release, pushes one entry
        // for each cycle in which a pixel tick is due.
        initial begin
            int n_pos;
            n_pos = 0;
            forever begin
                @(posedge clk);
                if (!rst_n) begin
                    n_pos = 0;
                    exp_q.delete();
                end else begin
                    n_pos++;
                    if (n_pos % DIV == DIV - 1)
                        exp_q.push_back(expect_at(n_pos / DIV));
                end
            end
        end

        // Scene memory: valid data only for the tick edge, noise otherwise.
        initial begin
            pixel_in = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    hist_h.delete();
                    hist_v.delete();
                    pixel_in = 12'($urandom);
                end else if (pix_tick) begin
                    hist_h.push_back(int'(h_cnt));
                    hist_v.push_back(int'(v_cnt));
                    if (hist_h.size() > DLY + 1) begin
                        void'(hist_h.pop_front());
                        void'(hist_v.pop_front());
                    end
                    if (hist_h.size() == DLY + 1)
                        pixel_in = 12'(scene(hist_h[0], hist_v[0]));
                    else
                        pixel_in = 12'($urandom);
                end else begin
                    pixel_in = 12'($urandom);
                end
            end
        end

        // Monitor: compares DUT against the scoreboard away from the active edge.
        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    check(gi, "rst h_cnt", int'(h_cnt), 0);
                    check(gi, "rst v_cnt", int'(v_cnt), 0);
                    check(gi, "rst pix_tick", int'(pix_tick), 0);
                    check(gi, "rst frame_start", int'(frame_start), 0);
                    check(gi, "rst hsync", int'(hsync), 1);
                    check(gi, "rst vsync", int'(vsync), 1);
                    check(gi, "rst rgb", int'({vga_r, vga_g, vga_b}), 0);
                end else begin
                    check(gi, "pix_tick", int'(pix_tick), int'(exp_q.size() > 0));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check(gi, "h_cnt", int'(h_cnt), e.h);
                        check(gi, "v_cnt", int'(v_cnt), e.v);
                        check(gi, "frame_start", int'(frame_start), int'(e.fs));
                        check(gi, "hsync", int'(hsync), int'(e.hs));
                        check(gi, "vsync", int'(vsync), int'(e.vs));
                        check(gi, "vga_r", int'(vga_r), e.r);
                        check(gi, "vga_g", int'(vga_g), e.g);
                        check(gi, "vga_b", int'(vga_b), e.b);
                    end else begin
                        check(gi, "frame_start idle", int'(frame_start), 0);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        seed       = int'($urandom);
        const_mode = 1'b0;
        rst_n      = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;

        // Random scene, then an asynchronous reset in the middle of a frame.
        repeat (6000 + $urandom_range(0, 500)) @(posedge clk);
        guard = 0;
        @(posedge clk);
        #2;
        while (!(g_dut[1].h_cnt == 10'd12 && g_dut[1].v_cnt == 10'd7) && guard < 5000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check(1, "reach mid-frame point", int'(guard < 5000), 1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        const_mode = 1'b1;
        #2 rst_n = 1'b1;

        // Flat 12'hABC scene.
        repeat (8000) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        const_mode = 1'b0;
        seed       = int'($urandom);
        #2 rst_n = 1'b1;

        // Fresh random scene after a short reset.
        repeat (5000) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
